anubis_round_ctrl: RTL and testbench
====================================

Name: anubis_round_ctrl

Overview:
- Round sequencer for the Anubis encryption/decryption datapath.
- Accepts one 128-bit block over a valid/ready handshake.
- Steps the external combinational round function through its modes:
  - key addition sigma[K0]
  - R-1 full rounds: sigma[Kr]·theta·tau·gamma
  - final round: sigma[KR]·tau·gamma
- Fetches round keys from the key schedule over a req/valid handshake and returns the result over valid/ready.

Parameters:
- ROUNDS, 12, total round count R. Legal range 12..18. R = 8 + N for a 32N-bit key.
- IDX_W, 5, width of rk_idx. Must satisfy 2^IDX_W > ROUNDS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  controller can accept a block. Combinational, equal to (state==IDLE).
- data_in  in  128  plaintext or ciphertext block.
- rk_req  out  1  round key requested.
- rk_idx  out  IDX_W  index of the requested key, 0..ROUNDS.
- rk_valid  in  1  key on rk is valid for rk_idx.
- rk  in  128  round key.
- rf_state  out  128  current state register, drives the round function.
- rf_key  out  128  equals rk, passed through to the round function.
- rf_mode  out  2  round function mode: 0 = KEY_ADD, 1 = FULL, 2 = FINAL, 3 = unused.
- rf_result  in  128  combinational round function output.
- out_valid  out  1  result block valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  128  result block, equal to the state register.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - state = IDLE
  - state register = 0
  - round counter = 0
  - rk_req = 0, out_valid = 0, busy = 0
  - in_ready = 1
- FSM has three states: IDLE, ROUND, OUT.
- IDLE:
  - On in_valid & in_ready: state_reg <= data_in, cnt <= 0, go to ROUND.
- ROUND:
  - rk_req = 1, rk_idx = cnt.
  - rf_mode = KEY_ADD if cnt==0, FINAL if cnt==ROUNDS, else FULL.
  - On rk_valid:
    - state_reg <= rf_result.
    - If cnt==ROUNDS: go to OUT.
    - Else: cnt <= cnt+1.
  - Without rk_valid: hold state_reg and cnt. Any number of stall cycles is allowed.
- OUT:
  - out_valid = 1, data_out = state_reg, stable until out_ready.
  - On out_ready: go to IDLE and clear cnt. state_reg holds its value.
- rk_req is asserted only in ROUND. rk_valid outside ROUND is ignored.
- Latency with rk_valid held high: ROUNDS+1 ROUND cycles after the accept cycle. out_valid rises in the cycle after the final-round key is consumed. For ROUNDS=12: accept at cycle 0, out_valid at cycle 14.
- Throughput: one block per ROUNDS+3 cycles minimum, counting accept, rounds and output. No overlap between blocks.
- in_valid during busy is ignored; in_ready stays 0.
- out_ready while not in OUT has no effect.
- Asynchronous reset mid-operation immediately forces the reset values. The in-flight block is discarded.
- rf_mode = 3 is never driven.
- rf_key is combinationally tied to rk. Key validity is qualified only by rk_valid.

Optional Feature:
- Macro: ANUBIS_ROUND_CTRL_ABORT_EN.
- When defined, add port abort (in, 1).
  - abort = 1 in ROUND or OUT: next state = IDLE, cnt <= 0, state_reg <= 0. out_valid drops in the next cycle.
  - abort has priority over rk_valid and out_ready in the same cycle.
  - abort in IDLE is ignored, and in_valid in that cycle is still accepted.
- When not defined: the port does not exist and the only exit from OUT is out_ready.

Test Plan:
Bench round-function model for all scenarios: rf_result = rf_state ^ rf_key, key schedule returns rk = {16{rk_idx[7:0]}}, ROUNDS=12.
- Basic run: data_in = 0, rk_valid and out_ready held high -> rf_mode sequence 0, then 1 x11, then 2. rk_idx sequence 0..12. out_valid at cycle 14. data_out = {16{8'h0C}}.
- Key stalls: rk_valid low for 3 cycles at every index -> same data_out {16{8'h0C}}. rk_idx holds during each stall. out_valid at cycle 14+39 = 53.
- Output back-pressure: out_ready low for 5 cycles -> out_valid and data_out stable for all 5. in_ready = 0 throughout. IDLE entered the cycle after out_ready rises.
- Ignored input: in_valid pulsed with data_in = {16{8'hFF}} during ROUND -> result unchanged, {16{8'h0C}}. The second block is accepted only after returning to IDLE. With data_in = {16{8'hFF}} the result is {16{8'hF3}}.
- Reset mid-run: rst_n driven low at cnt = 6 -> immediately busy = 0, rk_req = 0, out_valid = 0, in_ready = 1. A new block afterwards completes normally.
- Abort, with ANUBIS_ROUND_CTRL_ABORT_EN defined: abort asserted at cnt = 4 together with rk_valid -> IDLE next cycle, state_reg = 0, no out_valid pulse.

Source files
------------

// File: rtl/anubis_round_ctrl.sv
// Round sequencer for the Anubis cipher datapath.
// Accepts one 128-bit block, then walks the external round function through
// key addition, ROUNDS-1 full rounds and the final round, fetching one round
// key per step. The result is returned over a valid/ready handshake.
// Optional build macro ANUBIS_ROUND_CTRL_ABORT_EN adds an abort input that
// returns the controller to IDLE and clears the state register.
//
// state | meaning
// IDLE  | waiting for an input block, in_ready high
// ROUND | requesting key rk_idx=cnt, applying round function when it arrives
// OUT   | result block presented on data_out until out_ready
module anubis_round_ctrl #(
   parameter int ROUNDS = 12,
   parameter int IDX_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     data_in,
   output logic             rk_req,
   output logic [IDX_W-1:0] rk_idx,
   input  logic             rk_valid,
   input  logic [127:0]     rk,
   output logic [127:0]     rf_state,
   output logic [127:0]     rf_key,
   output logic [1:0]       rf_mode,
   input  logic [127:0]     rf_result,
`ifdef ANUBIS_ROUND_CTRL_ABORT_EN
   input  logic             abort,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     data_out,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      OUT   = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

   localparam logic [1:0] MODE_KEY_ADD = 2'd0;
   localparam logic [1:0] MODE_FULL    = 2'd1;
   localparam logic [1:0] MODE_FINAL   = 2'd2;

   state_t           state;
   logic [IDX_W-1:0] cnt;
   logic [127:0]     state_reg;
   logic             abort_req;

`ifdef ANUBIS_ROUND_CTRL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Sequencer: state, round counter, state register and registered flags.
   // Flags are updated together with the transition so they always match state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         state_reg <= '0;
         rk_req    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // abort is meaningless here, so a same-cycle block is still taken
               if (in_valid) begin
                  state     <= ROUND;
                  state_reg <= data_in;
                  cnt       <= '0;
                  rk_req    <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ROUND: begin
               if (abort_req) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  state_reg <= '0;
                  rk_req    <= 1'b0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (rk_valid) begin
                  state_reg <= rf_result;
                  if (cnt == LAST_IDX) begin
                     state     <= OUT;
                     rk_req    <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            OUT: begin
               if (abort_req) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  state_reg <= '0;
                  rk_req    <= 1'b0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (out_ready) begin
                  // result stays visible on data_out after the handshake
                  state     <= IDLE;
                  cnt       <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               rk_req    <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Round function mode decoded from the round counter; never drives 3.
   always_comb begin
      rf_mode = MODE_FULL;
      if (cnt == '0)
         rf_mode = MODE_KEY_ADD;
      else if (cnt == LAST_IDX)
         rf_mode = MODE_FINAL;
   end

   assign in_ready = (state == IDLE);
   assign rk_idx   = cnt;
   assign rf_state = state_reg;
   assign rf_key   = rk;
   assign data_out = state_reg;

endmodule

// File: tb/tb_anubis_round_ctrl.sv
// Directed bench for anubis_round_ctrl (ROUNDS=12). The bench supplies a
// trivial round function (state ^ key) and a key schedule returning
// {16{idx}}, so the final result is data_in ^ {16{8'h0C}}.
module tb_anubis_round_ctrl;
   localparam int ROUNDS = 12;
   localparam int IDX_W  = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [127:0]     data_in = '0;
   logic             rk_req;
   logic [IDX_W-1:0] rk_idx;
   logic             rk_valid = 1'b0;
   logic [127:0]     rk;
   logic [127:0]     rf_state;
   logic [127:0]     rf_key;
   logic [1:0]       rf_mode;
   logic [127:0]     rf_result;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [127:0]     data_out;
   logic             busy;
`ifdef ANUBIS_ROUND_CTRL_ABORT_EN
   logic             abort = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0] idx8;
   assign idx8      = {3'b000, rk_idx};
   assign rk        = {16{idx8}};
   assign rf_result = rf_state ^ rf_key;

   anubis_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .rk_req    (rk_req),
      .rk_idx    (rk_idx),
      .rk_valid  (rk_valid),
      .rk        (rk),
      .rf_state  (rf_state),
      .rf_key    (rf_key),
      .rf_mode   (rf_mode),
      .rf_result (rf_result),
`ifdef ANUBIS_ROUND_CTRL_ABORT_EN
      .abort     (abort),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] din;
      int           stall;   // rk_valid-low cycles before each key
      int           bp;      // cycles out_ready is low while out_valid is high
      bit           poke;    // pulse in_valid with all-ones during ROUND
      logic [127:0] exp;
      int           lat;     // cycle of first out_valid, accept = cycle 0
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_block(input vec_t v);
      int           cyc;
      int           wait_cnt;
      int           idx_exp;
      logic [127:0] model;
      logic [1:0]   mode_exp;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      in_valid  = 1'b1;
      data_in   = v.din;
      out_ready = (v.bp == 0);
      rk_valid  = 1'b0;
      cyc = 0; wait_cnt = 0; idx_exp = 0; model = v.din;
      while (!out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b0;
         if (v.poke && cyc == 3) begin
            in_valid = 1'b1;
            data_in  = {16{8'hFF}};
         end
         if (rk_req) begin
            mode_exp = (idx_exp == 0) ? 2'd0 : (idx_exp == ROUNDS) ? 2'd2 : 2'd1;
            chk("rk_idx", rk_idx, idx_exp);
            chk("rf_mode", rf_mode, mode_exp);
            chk("rf_state", rf_state, model);
            chk("round_in_ready", in_ready, 0);
            chk("round_busy", busy, 1);
            if (wait_cnt == v.stall) begin
               rk_valid = 1'b1;
               wait_cnt = 0;
               model    = model ^ {16{8'(idx_exp)}};
               idx_exp++;
            end else begin
               rk_valid = 1'b0;
               wait_cnt++;
            end
         end else begin
            rk_valid = 1'b0;
         end
      end
      rk_valid = 1'b0;
      in_valid = 1'b0;
      chk("latency", cyc, v.lat);
      chk("data_out", data_out, v.exp);
      chk("out_rk_req", rk_req, 0);
      chk("out_in_ready", in_ready, 0);
      for (int k = 1; k < v.bp; k++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_data_out", data_out, v.exp);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_hold", data_out, v.exp);
   endtask

   initial begin
      vecs[0] = '{128'h0, 0, 0, 1'b0, {16{8'h0C}}, 14};
      vecs[1] = '{128'h0, 3, 0, 1'b0, {16{8'h0C}}, 53};
      vecs[2] = '{{16{8'hAA}}, 0, 5, 1'b0, {16{8'hA6}}, 14};
      vecs[3] = '{128'h0, 0, 0, 1'b1, {16{8'h0C}}, 14};
      vecs[4] = '{{16{8'hFF}}, 0, 0, 1'b0, {16{8'hF3}}, 14};
      vecs[5] = '{128'h00112233445566778899AABBCCDDEEFF, 1, 2, 1'b0,
                  128'h0C1D2E3F48596A7B8495A6B7C0D1E2F3, 27};

      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rk_req", rk_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_state", rf_state, 0);
      chk("rst_rk_idx", rk_idx, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_block(vecs[i]);

      // Reset while cnt = 6
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = {16{8'h55}};
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         rk_valid = 1'b1;
         if (rk_req && rk_idx == 5'd6) break;
      end
      chk("pre_rst_idx", rk_idx, 6);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rk_req", rk_req, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_state", rf_state, 0);
      rk_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_block(vecs[0]);

`ifdef ANUBIS_ROUND_CTRL_ABORT_EN
      // Abort at cnt = 4 together with rk_valid
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = {16{8'h33}};
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         rk_valid = 1'b1;
         if (rk_req && rk_idx == 5'd4) break;
      end
      chk("pre_abort_idx", rk_idx, 4);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_state", rf_state, 0);
      chk("abort_rk_req", rk_req, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("abort_no_out_valid", out_valid, 0);
      end
      rk_valid = 1'b0;
      // abort in IDLE does not block an accept
      abort    = 1'b1;
      in_valid = 1'b1;
      data_in  = {16{8'h77}};
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_idle_accept", busy, 1);
      chk("abort_idle_state", rf_state, {16{8'h77}});
      @(negedge clk);
      abort = 1'b0;
      chk("abort_round_exit", in_ready, 1);
      run_block(vecs[4]);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
